// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding, reset direction and reversal test.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_W = 2'b00,
    DIR_A = 2'b01,
    DIR_S = 2'b10,
    DIR_D = 2'b11
  } dir_t;

  localparam dir_t DIR_RESET = DIR_D;

  // W<->S and A<->D differ only in the upper bit.
  function automatic logic isOpposite(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_direction_control_if.sv
// Key/pause inputs and direction/move-pulse outputs of the direction controller.
interface snake_direction_control_if;

  logic            keyW;
  logic            keyA;
  logic            keyS;
  logic            keyD;
  logic            pause;
  snake_pkg::dir_t snakeDirection;
  logic            enable;

  modport master (
    output keyW, keyA, keyS, keyD, pause,
    input  snakeDirection, enable
  );

  modport slave (
    input  keyW, keyA, keyS, keyD, pause,
    output snakeDirection, enable
  );

endinterface

// File: rtl/snake_tick_gen.sv
// Free-running move-tick counter with a registered one-cycle pulse; freezes while paused.
module snake_tick_gen #(
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // High in the cycle whose closing edge raises the pulse.
  assign tick_c = !pause && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_c;
      if (tick_c) begin
        count <= '0;
      end else if (!pause) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_direction_control.sv
// Turns W/A/S/D key edges into a committed snake direction, blocking 180-degree reversals.
module snake_direction_control
  import snake_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input logic                      clk,
  input logic                      reset,
  snake_direction_control_if.slave bus
);

  logic [3:0] keys;
  logic [3:0] prevKeys;
  logic [3:0] rise;
  logic       reqValid;
  logic       tick_c;
  dir_t       req;
  dir_t       refDir;
  dir_t       nextDir;

  snake_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .pause  (bus.pause),
    .tick   (bus.enable),
    .tick_c (tick_c)
  );

  assign keys = {bus.keyW, bus.keyA, bus.keyS, bus.keyD};
  assign rise = keys & ~prevKeys;

  // Priority W > A > S > D among keys rising together.
  always_comb begin
    reqValid = |rise;
    req      = DIR_D;
    if (rise[3])      req = DIR_W;
    else if (rise[2]) req = DIR_A;
    else if (rise[1]) req = DIR_S;
  end

  // On a commit cycle the request is judged against the direction being committed.
  assign refDir = tick_c ? nextDir : bus.snakeDirection;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.snakeDirection <= DIR_RESET;
      nextDir            <= DIR_RESET;
      prevKeys           <= '0;
    end else begin
      prevKeys <= keys;
      if (tick_c) begin
        bus.snakeDirection <= nextDir;
      end
      if (reqValid && !isOpposite(req, refDir)) begin
        nextDir <= req;
      end
    end
  end

endmodule

// File: tb/tb_snake_direction_control.sv
// Self-checking bench: directed scenarios plus random keys/pause against a behavioural model.
module tb_snake_direction_control;
  import snake_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;

  snake_direction_control_if bus();

  snake_direction_control #(.TICK_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a tick lands on every T-th unpaused edge; requests come from key rises.
  int         mDir  = 3;
  int         mNext = 3;
  int         mUnp  = 0;
  int         mReq;
  int         mRef;
  bit         mTick;
  logic       mEn   = 1'b0;
  logic [3:0] mPrev = 4'b0;
  logic [3:0] mKeys;
  logic [3:0] mRise;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mDir  = 3;
      mNext = 3;
      mUnp  = 0;
      mEn   = 1'b0;
      mPrev = 4'b0;
    end else begin
      mKeys = {bus.keyW, bus.keyA, bus.keyS, bus.keyD};
      mRise = mKeys & ~mPrev;
      mTick = !bus.pause && ((mUnp % T) == T - 1);
      if (!bus.pause) mUnp++;
      mRef = mTick ? mNext : mDir;
      mReq = -1;
      for (int i = 3; i >= 0; i--) begin
        if (mRise[i] && mReq < 0) mReq = 3 - i;
      end
      if (mTick) mDir = mNext;
      if (mReq >= 0 && ((mReq ^ mRef) != 2)) mNext = mReq;
      mEn   = mTick;
      mPrev = mKeys;
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset === 1'b0) begin
      check("dir_vs_model", int'(bus.snakeDirection), mDir);
      check("enable_vs_model", int'(bus.enable), int'(mEn));
    end
  end

  task automatic setKey(input int idx, input logic v);
    case (idx)
      0:       bus.keyW = v;
      1:       bus.keyA = v;
      2:       bus.keyS = v;
      default: bus.keyD = v;
    endcase
  endtask

  // Key idx (0=W,1=A,2=S,3=D) high for the given number of cycles, driven on negedges.
  task automatic press(input int idx, input int cycles);
    @(negedge clk);
    setKey(idx, 1'b1);
    repeat (cycles) @(negedge clk);
    setKey(idx, 1'b0);
  endtask

  // Returns just after the edge that raises enable; a missing pulse is a failed check.
  task automatic waitTick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * T; i++) begin
      @(posedge clk);
      #1;
      if (bus.enable) begin
        found = 1'b1;
        break;
      end
    end
    check(name, int'(found), 1);
  endtask

  task automatic cadence(input string name, input int edges);
    for (int i = 1; i <= edges; i++) begin
      @(posedge clk);
      #1;
      check(name, int'(bus.enable), (i % T == 0) ? 1 : 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.keyW  = 1'b0;
    bus.keyA  = 1'b0;
    bus.keyS  = 1'b0;
    bus.keyD  = 1'b0;
    bus.pause = 1'b0;
    #3;
    check("reset_dir", int'(bus.snakeDirection), 3);
    check("reset_enable", int'(bus.enable), 0);
    @(negedge clk);
    reset = 1'b0;

    cadence("cadence", 12);
    check("cadence_dir", int'(bus.snakeDirection), 3);

    press(0, 1);
    check("turn_w_pending", int'(bus.snakeDirection), 3);
    waitTick("turn_w_tick");
    check("turn_w_commit", int'(bus.snakeDirection), 0);

    press(2, 1);
    waitTick("rev_s_tick1");
    waitTick("rev_s_tick2");
    check("rev_s_blocked", int'(bus.snakeDirection), 0);

    press(3, 1);
    waitTick("turn_d_tick");
    check("turn_d_commit", int'(bus.snakeDirection), 3);

    press(1, 1);
    waitTick("rev_a_tick1");
    waitTick("rev_a_tick2");
    check("rev_a_blocked", int'(bus.snakeDirection), 3);

    press(0, 1);
    press(1, 1);
    waitTick("double_tick");
    check("double_turn", int'(bus.snakeDirection), 0);

    press(1, 1);
    waitTick("to_a_tick");
    check("to_a", int'(bus.snakeDirection), 1);
    press(2, 10);
    waitTick("held_s_tick");
    check("held_s", int'(bus.snakeDirection), 2);

    press(1, 1);
    waitTick("back_a_tick");
    check("back_a", int'(bus.snakeDirection), 1);
    @(negedge clk);
    bus.keyW = 1'b1;
    bus.keyD = 1'b1;
    @(negedge clk);
    bus.keyW = 1'b0;
    bus.keyD = 1'b0;
    waitTick("simul_tick");
    check("simul_wd", int'(bus.snakeDirection), 0);

    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("pause_no_enable", int'(bus.enable), 0);
    end
    @(negedge clk);
    bus.pause = 1'b0;
    @(posedge clk);
    #1;
    check("pause_resume_1", int'(bus.enable), 0);
    @(posedge clk);
    #1;
    check("pause_resume_2", int'(bus.enable), 1);

    repeat (4) @(negedge clk);
    bus.keyD = 1'b1;
    @(posedge clk);
    #1;
    check("same_cycle_enable", int'(bus.enable), 1);
    check("same_cycle_dir", int'(bus.snakeDirection), 0);
    @(negedge clk);
    bus.keyD = 1'b0;
    waitTick("same_cycle_next_tick");
    check("same_cycle_commit", int'(bus.snakeDirection), 3);

    press(0, 1);
    waitTick("pre_reset_tick");
    check("pre_reset_dir", int'(bus.snakeDirection), 0);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_dir", int'(bus.snakeDirection), 3);
    check("async_reset_enable", int'(bus.enable), 0);
    @(negedge clk);
    reset = 1'b0;
    cadence("cadence_after_reset", 8);

    repeat (400) begin
      @(negedge clk);
      bus.keyW = ($urandom_range(0, 3) == 0);
      bus.keyA = ($urandom_range(0, 3) == 0);
      bus.keyS = ($urandom_range(0, 3) == 0);
      bus.keyD = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
    end
    @(negedge clk);
    bus.keyW  = 1'b0;
    bus.keyA  = 1'b0;
    bus.keyS  = 1'b0;
    bus.keyD  = 1'b0;
    bus.pause = 1'b0;
    repeat (2 * T) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_direction_control.md
# snake_direction_control

Produces the `snakeDirection` and `enable` inputs that drive the snake-head position register. It turns W/A/S/D key presses into a latched 2-bit direction and blocks 180° reversals. It also generates the periodic one-cycle move tick. The block sits between the keyboard/key-input logic and the head-position register, and owns game speed and turn legality.

## Interface
Parameters:
- `TICK_CYCLES`, default 25_000_000: clock cycles per move tick (0.5 s at 50 MHz). Legal range is ≥ 2.

Ports:
- `clk` in, 1 bit: system clock, the only clock.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `keyW` / `keyA` / `keyS` / `keyD` in, 1 bit each: key levels, high = pressed. Already synchronous to `clk` (synchronized upstream).
- `pause` in, 1 bit: while high, the tick counter freezes and no move pulses are issued.
- `snakeDirection` out, 2 bits: committed direction. Encoding is 00 = W (X−1), 01 = A (Y+1), 10 = S (X+1), 11 = D (Y−1).
- `enable` out, 1 bit: move pulse, high for exactly one cycle per tick.

## Operation
- Reset values, applied asynchronously while `reset` is high:
  - `snakeDirection` = 2'b11.
  - Pending direction `nextDir` = 2'b11.
  - Tick counter = 0.
  - `enable` = 0.
  - Previous-key registers = 0.
- Key edge detection:
  - One request is generated per rising edge of each key (key high now, low last cycle).
  - A held key produces no further requests.
  - If several keys rise in the same cycle, priority is W > A > S > D; the rest are dropped.
- Reversal rule:
  - A direction is opposite when `req ^ ref == 2'b10` (W↔S, A↔D).
  - `ref` is the committed `snakeDirection`. In a tick cycle only, `ref` is `nextDir`, the value being committed that cycle.
  - An opposite request is ignored. Any other request, including the same direction, is written to `nextDir`; the last accepted request before a tick wins.
- Commit: on the edge where `enable` is set to 1, `snakeDirection <= nextDir`. The direction therefore changes only together with a move pulse.
- Request in the same cycle as a tick:
  - `snakeDirection` takes the old `nextDir`.
  - `nextDir` takes the new request, if legal against the old `nextDir`.
  - The request takes effect at the following tick.
- Tick generator:
  - The counter runs 0..TICK_CYCLES−1 and wraps to 0.
  - `enable <= !pause && (count == TICK_CYCLES−1)`.
  - The counter holds its value while `pause` is high.
- Pause: key requests are still accepted and `nextDir` still updates. `snakeDirection` does not change until ticks resume.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- First `enable` after reset release: set on rising edge number TICK_CYCLES (counting the first post-release edge as 1). After that, it is set every TICK_CYCLES edges. Each pulse lasts exactly one cycle.
- Key-to-`nextDir` latency: 1 cycle after the edge that samples the key high.
- Key-to-`snakeDirection` latency: up to the next tick.
- Pause releases resume counting from the frozen value. A pause asserted in the cycle with `count == TICK_CYCLES−1` suppresses that pulse, and the counter stays at TICK_CYCLES−1.
- Reset asserted mid-count clears everything immediately, with no clock needed. The first tick after release follows the rule above.
- Counter width is `$clog2(TICK_CYCLES)`. The wrap comparison is exact and must not overflow at any legal parameter value.

## Structure
- Shared package `snake_pkg`:
  - `typedef enum logic [1:0] {DIR_W=2'b00, DIR_A=2'b01, DIR_S=2'b10, DIR_D=2'b11} dir_t`.
  - Function `isOpposite(dir_t a, dir_t b)`.
  - Constant `DIR_RESET = DIR_D`.
  - `snakeHeadControl` and future body/collision blocks import the same package.
- Sub-module `snake_tick_gen`:
  - Ports: `clk`, `reset`, `pause`, and `tick` out.
  - Parameter: `TICK_CYCLES`.
  - Contains the counter and the registered pulse. Direction logic stays at top level.
- Expected size: about 150 RTL lines in total.

## Test plan
All scenarios use TICK_CYCLES = 4.
- **Reset and tick cadence:** assert `reset` then release, all keys low. Outputs read `snakeDirection` = 11 and `enable` = 0. `enable` pulses on edges 4, 8, 12, one cycle each.
- **Legal turn:** with direction 11, pulse `keyW` between ticks. `snakeDirection` stays 11 until the next `enable`, then reads 00 on the same edge `enable` rises.
- **Reversal blocked:** with direction 11, pulse `keyA`. After two ticks `snakeDirection` is still 11. Repeat with direction 00 and `keyS`: it stays 00.
- **Double turn within one tick:** with direction 11, press `keyW`, then `keyA` two cycles later, both before the tick. After the tick `snakeDirection` = 00, because A was checked against committed D and rejected.
- **Held and simultaneous keys:**
  - Hold `keyS` for 10 cycles from direction 01: one request only, and direction reads 10 after the tick.
  - Raise `keyW` and `keyD` on the same edge from direction 01: direction reads 00.
- **Pause and async reset:**
  - Assert `pause` at count 2 for 6 cycles: no `enable`. The next pulse comes 2 cycles after release.
  - Request plus tick in the same cycle: the new request is committed at the next tick.
  - Assert `reset` between edges: outputs go to 11/0 immediately.
